qnigma_ram_arb: RTL and testbench

QNIGMA_RAM_ARB -- requirements
Module: qnigma_ram_arb

---
 rtl/qnigma_ram_arb.sv | 119 +++++++++++
 tb/tb_qnigma_ram_arb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/qnigma_ram_arb.sv
// +--------------------------------------------------------------------------+
// | qnigma_ram_arb : round-robin single-port RAM arbiter with lock support   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module qnigma_ram_arb #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int NR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR-1:0]    req,
  input  logic [NR-1:0]    wr,
  input  logic [NR-1:0]    lock,
  input  logic [NR*AW-1:0] addr,
  input  logic [NR*DW-1:0] wdata,
  output logic [NR-1:0]    gnt,
  output logic [NR-1:0]    rd_vld,
  output logic [DW-1:0]    rd_data,
  output logic [AW-1:0]    ram_a,
  output logic [DW-1:0]    ram_d,
  output logic             ram_w,
  input  logic [DW-1:0]    ram_q
);

  localparam int IW = $clog2(NR);

  logic [AW-1:0] w_addr_arr  [NR];
  logic [DW-1:0] w_wdata_arr [NR];

  logic [NR-1:0] w_lock_mask;
  logic [NR-1:0] w_elig;
  logic [NR-1:0] w_gnt;
  logic [NR-1:0] w_s1_dec;
  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_idx;
  logic          w_any;

  logic [IW-1:0] r_last;
  logic [IW-1:0] r_lock_own;
  logic          r_lock_vld;
  logic [IW-1:0] r_s1_idx;
  logic          r_s1_vld;

  genvar gk;
  generate
    for (gk = 0; gk < NR; gk++) begin : g_unpack
      assign w_addr_arr[gk]  = addr[gk*AW +: AW];
      assign w_wdata_arr[gk] = wdata[gk*DW +: DW];
    end
  endgenerate

  // Search starts one past the last winner; a lock narrows eligibility to its owner.
  always_comb begin
    w_lock_mask = '1;
    if (r_lock_vld) begin
      w_lock_mask             = '0;
      w_lock_mask[r_lock_own] = 1'b1;
    end
    w_elig = req & w_lock_mask;
    w_any  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    for (int i = 1; i <= NR; i++) begin
      w_cand = IW'((int'(r_last) + i) % NR);
      if (!w_any && w_elig[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
    w_gnt = '0;
    if (w_any && rst_n) w_gnt[w_idx] = 1'b1;
  end

  always_comb begin
    w_s1_dec = '0;
    if (r_s1_vld) w_s1_dec[r_s1_idx] = 1'b1;
  end

  assign gnt     = w_gnt;
  assign rd_data = ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_a      <= '0;
      ram_d      <= '0;
      ram_w      <= 1'b0;
      rd_vld     <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_idx   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_own <= '0;
      r_last     <= IW'(NR - 1);
    end else begin
      ram_w    <= 1'b0;
      r_s1_vld <= w_any && !wr[w_idx];
      r_s1_idx <= w_idx;
      rd_vld   <= w_s1_dec;
      if (w_any) begin
        ram_a  <= w_addr_arr[w_idx];
        ram_d  <= w_wdata_arr[w_idx];
        ram_w  <= wr[w_idx];
        r_last <= w_idx;
      end
      // While owned, any grant necessarily belongs to the owner.
      if (r_lock_vld) begin
        if (!req[r_lock_own] || (w_any && !lock[w_idx])) r_lock_vld <= 1'b0;
      end else if (w_any && lock[w_idx]) begin
        r_lock_vld <= 1'b1;
        r_lock_own <= w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qnigma_ram_arb.sv
// +--------------------------------------------------------------------------+
// | tb_qnigma_ram_arb : directed vector bench for qnigma_ram_arb             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_qnigma_ram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, wr, lock;
  logic [15:0] a_arr [4];
  logic [15:0] d_arr [4];
  logic [63:0] addr, wdata;
  logic [3:0]  gnt, rd_vld;
  logic [15:0] rd_data, ram_a, ram_d, ram_q;
  logic        ram_w;
  logic [15:0] mem [256];

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [3:0]  lock;
    logic [3:0]  gnt;
    logic [3:0]  rdv;
    logic        ramw;
    logic [15:0] rdata;
  } vec_t;

  vec_t vec [31];

  assign addr  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign wdata = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};

  always #5 clk = ~clk;

  // RAM model: one-cycle registered read, preloaded with 0x1000+address during reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
    end else if (ram_w) begin
      mem[ram_a[7:0]] <= ram_d;
    end
    ram_q <= mem[ram_a[7:0]];
  end

  qnigma_ram_arb #(.AW(16), .DW(16), .NR(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wr      (wr),
    .lock    (lock),
    .addr    (addr),
    .wdata   (wdata),
    .gnt     (gnt),
    .rd_vld  (rd_vld),
    .rd_data (rd_data),
    .ram_a   (ram_a),
    .ram_d   (ram_d),
    .ram_w   (ram_w),
    .ram_q   (ram_q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l);
    req  = r;
    wr   = w;
    lock = l;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'hF, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      a_arr[k] = 16'h0020 + 16'(k);
      d_arr[k] = 16'hD000 + 16'(k);
    end

    //          req   wr    lock  gnt   rdv   ramw  rdata
    vec[0]  = '{4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 16'h0000};
    vec[1]  = '{4'hF, 4'h0, 4'h0, 4'h2, 4'h0, 1'b0, 16'h0000};
    vec[2]  = '{4'hF, 4'h0, 4'h0, 4'h4, 4'h1, 1'b0, 16'h1020};
    vec[3]  = '{4'hF, 4'h0, 4'h0, 4'h8, 4'h2, 1'b0, 16'h1021};
    vec[4]  = '{4'hF, 4'h0, 4'h0, 4'h1, 4'h4, 1'b0, 16'h1022};
    vec[5]  = '{4'hF, 4'h0, 4'h0, 4'h2, 4'h8, 1'b0, 16'h1023};
    vec[6]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 16'h1020};
    vec[7]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 16'h1021};
    vec[8]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000};
    vec[9]  = '{4'h9, 4'h0, 4'h0, 4'h8, 4'h0, 1'b0, 16'h0000};
    vec[10] = '{4'h9, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 16'h0000};
    vec[11] = '{4'h6, 4'h6, 4'h0, 4'h2, 4'h8, 1'b0, 16'h1023};
    vec[12] = '{4'h4, 4'h4, 4'h0, 4'h4, 4'h1, 1'b1, 16'h1020};
    vec[13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 16'h0000};
    vec[14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000};
    vec[15] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 16'h0000};
    vec[16] = '{4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 16'h0000};
    vec[17] = '{4'h3, 4'h0, 4'h0, 4'h2, 4'h0, 1'b0, 16'h0000};
    vec[18] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 16'h1020};
    vec[19] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 16'hD001};
    vec[20] = '{4'h3, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0, 16'h0000};
    vec[21] = '{4'h3, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0, 16'h0000};
    vec[22] = '{4'h3, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 16'h1020};
    vec[23] = '{4'h2, 4'h0, 4'h0, 4'h2, 4'h1, 1'b0, 16'h1020};
    vec[24] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 16'h1020};
    vec[25] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 16'hD001};
    vec[26] = '{4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 1'b0, 16'h0000};
    vec[27] = '{4'h8, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0, 16'h0000};
    vec[28] = '{4'h8, 4'h0, 4'h0, 4'h8, 4'h4, 1'b0, 16'hD002};
    vec[29] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000};
    vec[30] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 1'b0, 16'h1023};

    // Reset state with every requester asking.
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rd_vld", 32'(rd_vld), 32'h0);
      chk("rst_ram_w", 32'(ram_w), 32'h0);
      chk("rst_ram_a", 32'(ram_a), 32'h0);
    end

    // Table: release, fairness, writes, lock and lock-less rows.
    for (int i = 0; i < 31; i++) begin
      tick();
      if (i == 0) rst_n = 1'b1;
      drive(vec[i].req, vec[i].wr, vec[i].lock);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vec[i].gnt));
      chk($sformatf("v%0d_rd_vld", i), 32'(rd_vld), 32'(vec[i].rdv));
      chk($sformatf("v%0d_ram_w", i), 32'(ram_w), 32'(vec[i].ramw));
      if (vec[i].rdv != 4'h0)
        chk($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vec[i].rdata));
    end

    // Single read from requester 2 at 0x0010.
    a_arr[2] = 16'h0010;
    tick(); drive(4'h4, 4'h0, 4'h0); @(negedge clk);
    chk("rd1_gnt", 32'(gnt), 32'h4);
    tick(); drive(4'h0, 4'h0, 4'h0); @(negedge clk);
    chk("rd1_ram_a", 32'(ram_a), 32'h0010);
    chk("rd1_ram_w", 32'(ram_w), 32'h0);
    chk("rd1_early_vld", 32'(rd_vld), 32'h0);
    tick(); @(negedge clk);
    chk("rd1_rd_vld", 32'(rd_vld), 32'h4);
    chk("rd1_rd_data", 32'(rd_data), 32'h1010);
    tick(); @(negedge clk);
    chk("rd1_vld_once", 32'(rd_vld), 32'h0);

    // Write 0xBEEF to 0x0005 then read it back from requester 1.
    a_arr[1] = 16'h0005;
    d_arr[1] = 16'hBEEF;
    tick(); drive(4'h2, 4'h2, 4'h0); @(negedge clk);
    chk("wr_gnt", 32'(gnt), 32'h2);
    tick(); drive(4'h2, 4'h0, 4'h0); @(negedge clk);
    chk("wrrd_gnt", 32'(gnt), 32'h2);
    chk("wr_ram_w", 32'(ram_w), 32'h1);
    chk("wr_ram_a", 32'(ram_a), 32'h0005);
    chk("wr_ram_d", 32'(ram_d), 32'hBEEF);
    tick(); drive(4'h0, 4'h0, 4'h0); @(negedge clk);
    chk("wr_no_vld", 32'(rd_vld), 32'h0);
    tick(); @(negedge clk);
    chk("wrrd_rd_vld", 32'(rd_vld), 32'h2);
    chk("wrrd_rd_data", 32'(rd_data), 32'hBEEF);

    // Reset during an in-flight read.
    tick(); drive(4'h1, 4'h0, 4'h0); @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h1);
    tick(); rst_n = 1'b0; drive(4'h9, 4'h0, 4'h0); @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_vld", 32'(rd_vld), 32'h0);
    chk("mid_rst_ram_w", 32'(ram_w), 32'h0);
    chk("mid_rst_ram_a", 32'(ram_a), 32'h0);
    tick(); @(negedge clk);
    chk("mid_rst_vld2", 32'(rd_vld), 32'h0);
    tick(); rst_n = 1'b1; @(negedge clk);
    chk("post_rst_gnt0", 32'(gnt), 32'h1);
    chk("post_rst_vld", 32'(rd_vld), 32'h0);
    tick(); @(negedge clk);
    chk("post_rst_gnt3", 32'(gnt), 32'h8);
    chk("post_rst_vld2", 32'(rd_vld), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
